// File: rtl/alu_issue_arb.sv
// -----------------------------------------------------------------------------
// alu_issue_arb
//
// Purpose:
//   Shares NUM_FU ALU function units among NUM_REQ ready reservation-station
//   entries. Each cycle up to NUM_FU requesters are paired with free FUs. The
//   requester scan starts at a round-robin pointer, and free FUs are taken in
//   ascending index. A per-FU busy flag is held from issue until the FU reports
//   completion, or until a pipeline squash.
//
// Configuration macro:
//   ALU_ARB_DONE_BYPASS_EN - when defined, a busy FU that asserts fu_done counts
//                            as free in that same cycle and can be re-issued.
//                            When undefined, an FU freed by fu_done can only be
//                            granted from the next cycle.
//
// Ports:
//   clock           in   1              system clock, all state on posedge
//   reset           in   1              asynchronous active-high reset
//   req             in   NUM_REQ        bit i: RS entry i has an ALU op ready
//   squash          in   1              flush; kills all in-flight FU ops
//   fu_done         in   NUM_FU         bit k: FU k produced its result
//   req_grant       out  NUM_REQ        bit i: entry i issued this cycle
//   fu_issue_valid  out  NUM_FU         bit k: FU k receives a new op
//   fu_issue_idx    out  NUM_FU*REQ_W   slice k: requester index sent to FU k
//   fu_busy         out  NUM_FU         registered busy flags
// -----------------------------------------------------------------------------
module alu_issue_arb #(
  parameter  int NUM_REQ = 4,
  parameter  int NUM_FU  = 2,
  localparam int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic                    squash,
  input  logic [NUM_FU-1:0]       fu_done,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic [NUM_FU-1:0]       fu_issue_valid,
  output logic [NUM_FU*REQ_W-1:0] fu_issue_idx,
  output logic [NUM_FU-1:0]       fu_busy
);

  logic [NUM_FU-1:0] busy_q, busy_d;
  logic [REQ_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [NUM_FU-1:0] fu_free;
  logic [NUM_FU-1:0] fu_avail;
  logic [REQ_W-1:0]  cand;
  logic [REQ_W-1:0]  last_idx;
  logic              any_grant;
  logic              placed;
  int                scan;
  int                nxt_ptr;

`ifdef ALU_ARB_DONE_BYPASS_EN
  // A completing FU can accept a new op in the same cycle.
  assign fu_free = ~busy_q | (busy_q & fu_done);
`else
  assign fu_free = ~busy_q;
`endif

  // Allocation: walk requesters from rr_ptr with wrap-around. Each active
  // requester takes the lowest-indexed FU still available. This pairs the j-th
  // active requester with the j-th free FU and stops naturally once either
  // list runs out.
  always_comb begin
    // NOTE: every output of this block gets a default before any condition,
    // so no path leaves a value held and no latch is inferred.
    req_grant      = '0;
    fu_issue_valid = '0;
    fu_issue_idx   = '0;
    fu_avail       = fu_free;
    any_grant      = 1'b0;
    last_idx       = rr_ptr_q;
    cand           = '0;
    placed         = 1'b0;
    scan           = 0;
    if (!reset && !squash) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        // NOTE: blocking assignments are used here on purpose. Each loop
        // iteration must see fu_avail as updated by the earlier iterations.
        scan = int'(rr_ptr_q) + j;
        if (scan >= NUM_REQ) scan = scan - NUM_REQ;
        cand   = REQ_W'(scan);
        placed = 1'b0;
        if (req[cand]) begin
          for (int k = 0; k < NUM_FU; k++) begin
            if (!placed && fu_avail[k]) begin
              placed                         = 1'b1;
              fu_avail[k]                    = 1'b0;
              fu_issue_valid[k]              = 1'b1;
              fu_issue_idx[k*REQ_W +: REQ_W] = cand;
              req_grant[cand]                = 1'b1;
              last_idx                       = cand;
              any_grant                      = 1'b1;
            end
          end
        end
      end
    end
  end

  // Busy next state. Squash clears all flags. An issue sets the flag even if
  // fu_done is asserted in the same cycle, because the new op is now in flight.
  // fu_done on an idle FU clears a bit that is already 0, so it has no effect.
  always_comb begin
    busy_d = busy_q;
    for (int k = 0; k < NUM_FU; k++) begin
      if (squash)                 busy_d[k] = 1'b0;
      else if (fu_issue_valid[k]) busy_d[k] = 1'b1;
      else if (fu_done[k])        busy_d[k] = 1'b0;
    end
  end

  // The pointer moves to the entry after the last one granted in scan order.
  // It holds when nothing is granted, and also during a squash.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    nxt_ptr  = int'(last_idx) + 1;
    if (nxt_ptr >= NUM_REQ) nxt_ptr = 0;
    if (!squash && any_grant) rr_ptr_d = REQ_W'(nxt_ptr);
  end

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples values from before the clock edge.
    if (reset) begin
      busy_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      busy_q   <= busy_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign fu_busy = busy_q;

endmodule

// File: tb/tb_alu_issue_arb.sv
// -----------------------------------------------------------------------------
// tb_alu_issue_arb
//
// Directed testbench for alu_issue_arb with NUM_REQ=4 and NUM_FU=2. A model
// built from queues predicts the grant, issue and busy outputs on every falling
// edge. Hand-computed literal checks pin the key scenarios. Define
// ALU_ARB_DONE_BYPASS_EN for both the bench and the RTL to exercise the
// same-cycle re-issue variant.
// -----------------------------------------------------------------------------
module tb_alu_issue_arb;

  localparam int NUM_REQ = 4;
  localparam int NUM_FU  = 2;
  localparam int REQ_W   = 2;
`ifdef ALU_ARB_DONE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic [NUM_REQ-1:0]      req = '0;
  logic                    squash = 1'b0;
  logic [NUM_FU-1:0]       fu_done = '0;
  logic [NUM_REQ-1:0]      req_grant;
  logic [NUM_FU-1:0]       fu_issue_valid;
  logic [NUM_FU*REQ_W-1:0] fu_issue_idx;
  logic [NUM_FU-1:0]       fu_busy;

  int n_cmp = 0;
  int n_err = 0;

  alu_issue_arb #(.NUM_REQ(NUM_REQ), .NUM_FU(NUM_FU)) dut (
    .clock          (clock),
    .reset          (reset),
    .req            (req),
    .squash         (squash),
    .fu_done        (fu_done),
    .req_grant      (req_grant),
    .fu_issue_valid (fu_issue_valid),
    .fu_issue_idx   (fu_issue_idx),
    .fu_busy        (fu_busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: list the active requesters in round-robin order and the free FUs
  // in index order, then pair the two lists element by element.
  initial begin : compare_proc
    int act_q[$];
    int free_q[$];
    int r;
    int n;
    int last;
    logic [NUM_FU-1:0]       m_busy;
    int                      m_ptr;
    logic [NUM_REQ-1:0]      e_grant;
    logic [NUM_FU-1:0]       e_valid;
    logic [NUM_FU*REQ_W-1:0] e_idx;
    m_busy = '0;
    m_ptr  = 0;
    forever begin
      @(negedge clock);
      e_grant = '0;
      e_valid = '0;
      e_idx   = '0;
      n       = 0;
      last    = 0;
      if (reset) begin
        m_busy = '0;
        m_ptr  = 0;
      end else if (!squash) begin
        act_q.delete();
        free_q.delete();
        for (int j = 0; j < NUM_REQ; j++) begin
          r = (m_ptr + j) % NUM_REQ;
          if (req[r]) act_q.push_back(r);
        end
        for (int k = 0; k < NUM_FU; k++)
          if (!m_busy[k] || (BYPASS && fu_done[k])) free_q.push_back(k);
        n = (act_q.size() < free_q.size()) ? act_q.size() : free_q.size();
        for (int p = 0; p < n; p++) begin
          e_grant[act_q[p]]                 = 1'b1;
          e_valid[free_q[p]]                = 1'b1;
          e_idx[free_q[p]*REQ_W +: REQ_W]   = REQ_W'(act_q[p]);
        end
        if (n > 0) last = act_q[n-1];
      end
      check("model_req_grant", 32'(req_grant), 32'(e_grant));
      check("model_fu_issue_valid", 32'(fu_issue_valid), 32'(e_valid));
      check("model_fu_issue_idx", 32'(fu_issue_idx), 32'(e_idx));
      check("model_fu_busy", 32'(fu_busy), 32'(m_busy));
      @(posedge clock);
      if (reset) begin
        m_busy = '0;
        m_ptr  = 0;
      end else if (squash) begin
        m_busy = '0;
      end else begin
        for (int k = 0; k < NUM_FU; k++) begin
          if (e_valid[k])      m_busy[k] = 1'b1;
          else if (fu_done[k]) m_busy[k] = 1'b0;
        end
        if (n > 0) m_ptr = (last + 1) % NUM_REQ;
      end
    end
  end

  // Apply new inputs just after a rising edge. The literal checks then run
  // once the combinational outputs have settled.
  task automatic step(input logic [3:0] r, input logic s, input logic [1:0] d);
    @(posedge clock);
    #1;
    req     = r;
    squash  = s;
    fu_done = d;
    #1;
  endtask

  typedef struct packed {
    logic [3:0] r;
    logic       s;
    logic [1:0] d;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs = '{
      '{4'b1111, 1'b0, 2'b11}, '{4'b0101, 1'b0, 2'b10}, '{4'b1010, 1'b0, 2'b01},
      '{4'b0000, 1'b0, 2'b11}, '{4'b1110, 1'b0, 2'b00}, '{4'b0111, 1'b0, 2'b11},
      '{4'b1111, 1'b1, 2'b11}, '{4'b0010, 1'b0, 2'b00}, '{4'b1111, 1'b0, 2'b00}
    };

    // Reset held with requests pending: no grants.
    #1 reset = 1'b1;
    req = 4'b1111;
    @(posedge clock); #2;
    check("rst_grant", 32'(req_grant), 32'h0);
    check("rst_valid", 32'(fu_issue_valid), 32'h0);
    check("rst_busy",  32'(fu_busy), 32'h0);

    // Scenario 1: FU0<-0, FU1<-1.
    @(posedge clock); #1 reset = 1'b0; #1;
    check("s1_grant", 32'(req_grant), 32'b0011);
    check("s1_valid", 32'(fu_issue_valid), 32'b11);
    check("s1_idx",   32'(fu_issue_idx), 32'b01_00);
    step(4'b1111, 1'b0, 2'b00);
    check("s1_busy_next", 32'(fu_busy), 32'b11);
    check("s1_all_busy_grant", 32'(req_grant), 32'h0);

    // Scenario 2: FU0 completes while busy=11 and rr_ptr=2.
    step(4'b1111, 1'b0, 2'b01);
    if (BYPASS) begin
      check("s2_grant", 32'(req_grant), 32'b0100);
      check("s2_idx",   32'(fu_issue_idx), 32'b00_10);
    end else begin
      check("s2_grant", 32'(req_grant), 32'h0);
      check("s2_valid", 32'(fu_issue_valid), 32'h0);
    end
    step(4'b0000, 1'b0, 2'b00);
    check("s2_busy_next", 32'(fu_busy), BYPASS ? 32'b11 : 32'b10);
    step(4'b0001, 1'b0, 2'b00);

    // Scenario 4: squash while busy=11.
    step(4'b1111, 1'b1, 2'b00);
    check("s4_busy_before", 32'(fu_busy), 32'b11);
    check("s4_grant", 32'(req_grant), 32'h0);
    check("s4_valid", 32'(fu_issue_valid), 32'h0);
    step(4'b0000, 1'b0, 2'b00);
    check("s4_busy_next", 32'(fu_busy), 32'b00);

    // Reach busy=10.
    step(4'b0011, 1'b0, 2'b00);
    step(4'b0000, 1'b0, 2'b01);
    check("s5_busy_11", 32'(fu_busy), 32'b11);

    // Scenario 5: reset pulsed between edges.
    @(posedge clock); #1;
    req = 4'b1111; fu_done = 2'b00;
    check("s5_busy_10", 32'(fu_busy), 32'b10);
    #1 reset = 1'b1;
    #1;
    check("s5_rst_busy",  32'(fu_busy), 32'b00);
    check("s5_rst_grant", 32'(req_grant), 32'h0);
    check("s5_rst_valid", 32'(fu_issue_valid), 32'h0);
    check("s5_rst_idx",   32'(fu_issue_idx), 32'h0);
    #3 req = 4'b0000;
    reset = 1'b0;

    // Scenario 3 setup: rr_ptr=0 -> grant 2 -> ptr=3. Squash then clears busy.
    step(4'b0100, 1'b0, 2'b00);
    check("s3_pre_grant", 32'(req_grant), 32'b0100);
    check("s3_pre_idx",   32'(fu_issue_idx), 32'b00_10);
    step(4'b1111, 1'b1, 2'b00);
    check("s3_sq_grant", 32'(req_grant), 32'h0);
    // Scenario 3: wrap from rr_ptr=3.
    step(4'b1001, 1'b0, 2'b00);
    check("s3_busy",  32'(fu_busy), 32'b00);
    check("s3_grant", 32'(req_grant), 32'b1001);
    check("s3_valid", 32'(fu_issue_valid), 32'b11);
    check("s3_idx",   32'(fu_issue_idx), 32'b00_11);

    // Scenario 6 setup: reset, then grant 3 on FU0 -> ptr=0, busy=01.
    @(posedge clock); #1 req = 4'b0000; reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    step(4'b1000, 1'b0, 2'b00);
    check("s6_pre_grant", 32'(req_grant), 32'b1000);
    check("s6_pre_idx",   32'(fu_issue_idx), 32'b00_11);
    step(4'b0110, 1'b0, 2'b00);
    check("s6_busy",  32'(fu_busy), 32'b01);
    check("s6_grant", 32'(req_grant), 32'b0010);
    check("s6_valid", 32'(fu_issue_valid), 32'b10);
    check("s6_idx",   32'(fu_issue_idx), 32'b01_00);
    step(4'b0110, 1'b0, 2'b00);
    check("s6_wait_busy",  32'(fu_busy), 32'b11);
    check("s6_wait_grant", 32'(req_grant), 32'h0);

    // Mixed vectors, checked by the model only.
    foreach (vecs[i]) step(vecs[i].r, vecs[i].s, vecs[i].d);
    step(4'b0000, 1'b0, 2'b00);

    @(negedge clock); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
